fetch_buf_pp_2p: RTL and testbench

Parametrised multi-bank (ping-pong and up) two-port buffer for the fetch and deblock store paths.
- A producer fills one bank while a consumer drains another; banks are handed over by done/release pulses and tracked by an occupancy counter.
- Generalises the fixed 128x64 two-port RAM wrapper in width, depth and bank count, and adds bank-level flow control, read-valid tracking and a drop flag.
- Sits between the pixel/fetch engines and the external-memory interface.

---
 rtl/fetch_buf_pkg.sv | 18 +
 rtl/fetch_buf_pp_2p_ram.sv | 35 +++
 rtl/fetch_buf_pp_2p.sv | 101 ++++++++++
 tb/tb_fetch_buf_pp_2p.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_buf_pkg.sv
// Shared helpers for the multi-bank fetch buffer.
// Bank-index width and bank-count legality live here.
package fetch_buf_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit bank_n_ok(input int n);
    return (n >= 2) && (n <= 8) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fetch_buf_pp_2p_ram.sv
// Generic two-port array: synchronous write, registered read.
// Kept separate so a tech or FPGA macro can replace it.
module ram_2p_beh #(
  parameter int Addr_Width = 7,
  parameter int Word_Width = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [Addr_Width-1:0] waddr_i,
  input  logic [Word_Width-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [Addr_Width-1:0] raddr_i,
  output logic [Word_Width-1:0] rdata_o
);

  logic [Word_Width-1:0] mem_q [2**Addr_Width];
  logic [Word_Width-1:0] rdata_q;

  // storage itself is never cleared
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fetch_buf_pp_2p.sv
// Multi-bank ping-pong buffer between fetch engines and memory.
// Banks change hands on done pulses; cnt tracks full banks.
module fetch_buf_pp_2p
  import fetch_buf_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 6,
  parameter int BANK_N = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_done,
  output logic                    wr_rdy,
  input  logic                    rd_en,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [DATA_W-1:0]       rd_data,
  output logic                    rd_valid,
  input  logic                    rd_done,
  output logic                    rd_rdy,
  output logic [clog2(BANK_N):0]  full_cnt,
  output logic                    drop_flag
);

  localparam int BANK_W = clog2(BANK_N);
  localparam logic [BANK_W:0] FULL = (BANK_W + 1)'(BANK_N);

  if (!bank_n_ok(BANK_N)) begin : g_bad_bank_n
    $error("fetch_buf_pp_2p: BANK_N must be a power of two in 2..8");
  end

  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
  logic [BANK_W:0]   cnt_q, cnt_d;
  logic              rd_valid_q;
  logic              drop_q, drop_d;
  logic              wr_acc, wdn_acc, rd_acc, rdn_acc;

  assign wr_rdy   = (cnt_q != FULL);
  assign rd_rdy   = (cnt_q != '0);
  assign full_cnt = cnt_q;

  assign wr_acc  = wr_en & wr_rdy;
  assign wdn_acc = wr_done & wr_rdy;
  assign rd_acc  = rd_en & rd_rdy;
  assign rdn_acc = rd_done & rd_rdy;

  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    cnt_d     = cnt_q;
    if (wdn_acc) wr_bank_d = wr_bank_q + 1'b1;
    if (rdn_acc) rd_bank_d = rd_bank_q + 1'b1;
    unique case ({wdn_acc, rdn_acc})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // any strobe refused by flow control is remembered until reset
  assign drop_d = drop_q
                | ((wr_en | wr_done) & ~wr_rdy)
                | ((rd_en | rd_done) & ~rd_rdy);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank_q  <= '0;
      rd_bank_q  <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_acc;
      drop_q     <= drop_d;
    end
  end

  assign rd_valid  = rd_valid_q;
  assign drop_flag = drop_q;

  ram_2p_beh #(
    .Addr_Width (ADDR_W + BANK_W),
    .Word_Width (DATA_W)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .we_i    (wr_acc),
    .waddr_i ({wr_bank_q, wr_addr}),
    .wdata_i (wr_data),
    .re_i    (rd_acc),
    .raddr_i ({rd_bank_q, rd_addr}),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_fetch_buf_pp_2p.sv
// Bench: default 2-bank instance via vectors and sequences,
// 4-bank 32-bit instance via random traffic against a queue model.
module tb_fetch_buf_pp_2p;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic         a_we = 0, a_wdn = 0, a_re = 0, a_rdn = 0;
  logic [5:0]   a_wa = 0, a_ra = 0;
  logic [127:0] a_wd = 0;
  logic [127:0] a_rdat;
  logic         a_wrdy, a_rrdy, a_val, a_drop;
  logic [1:0]   a_cnt;

  fetch_buf_pp_2p u0 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(a_we), .wr_addr(a_wa), .wr_data(a_wd), .wr_done(a_wdn),
    .wr_rdy(a_wrdy),
    .rd_en(a_re), .rd_addr(a_ra), .rd_data(a_rdat), .rd_valid(a_val),
    .rd_done(a_rdn), .rd_rdy(a_rrdy),
    .full_cnt(a_cnt), .drop_flag(a_drop)
  );

  // 4-bank instance
  logic        b_we = 0, b_wdn = 0, b_re = 0, b_rdn = 0;
  logic [2:0]  b_wa = 0, b_ra = 0;
  logic [31:0] b_wd = 0;
  logic [31:0] b_rdat;
  logic        b_wrdy, b_rrdy, b_val, b_drop;
  logic [2:0]  b_cnt;

  fetch_buf_pp_2p #(.DATA_W(32), .ADDR_W(3), .BANK_N(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(b_we), .wr_addr(b_wa), .wr_data(b_wd), .wr_done(b_wdn),
    .wr_rdy(b_wrdy),
    .rd_en(b_re), .rd_addr(b_ra), .rd_data(b_rdat), .rd_valid(b_val),
    .rd_done(b_rdn), .rd_rdy(b_rrdy),
    .full_cnt(b_cnt), .drop_flag(b_drop)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step0(input logic we, input int wa, input logic [127:0] wd,
                       input logic wdn, input logic re, input int ra,
                       input logic rdn);
    a_we = we; a_wa = 6'(wa); a_wd = wd; a_wdn = wdn;
    a_re = re; a_ra = 6'(ra); a_rdn = rdn;
    @(negedge clk);
  endtask

  typedef struct {
    logic we; int wa; logic [127:0] wd; logic wdn;
    logic re; int ra; logic rdn;
    logic e_wrdy; logic e_rrdy; logic [1:0] e_cnt;
    logic e_val; logic [127:0] e_dat; logic e_drop;
  } vec_t;

  function automatic vec_t mk(logic we, int wa, logic [127:0] wd, logic wdn,
                              logic re, int ra, logic rdn,
                              logic ewr, logic err, logic [1:0] ec,
                              logic ev, logic [127:0] ed, logic edr);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.wdn = wdn;
    v.re = re; v.ra = ra; v.rdn = rdn;
    v.e_wrdy = ewr; v.e_rrdy = err; v.e_cnt = ec;
    v.e_val = ev; v.e_dat = ed; v.e_drop = edr;
    return v;
  endfunction

  vec_t tbl [13];

  task automatic chk_a(input string nm, input logic ewr, input logic err,
                       input logic [1:0] ec, input logic ev,
                       input logic [127:0] ed, input logic edr);
    chk({nm, ".wr_rdy"}, 128'(a_wrdy), 128'(ewr));
    chk({nm, ".rd_rdy"}, 128'(a_rrdy), 128'(err));
    chk({nm, ".full_cnt"}, 128'(a_cnt), 128'(ec));
    chk({nm, ".rd_valid"}, 128'(a_val), 128'(ev));
    chk({nm, ".rd_data"}, a_rdat, ed);
    chk({nm, ".drop_flag"}, 128'(a_drop), 128'(edr));
  endtask

  initial begin
    // state before vectors: full=2, wr_bank=1, rd_bank=1,
    // bank1 holds 1000+a, bank0 holds 2000+a, last rd_data 63
    tbl[0]  = mk(1, 5, 'hDEAD, 0, 0, 0, 0,  0, 1, 2, 0, 63,   1);
    tbl[1]  = mk(0, 0, 0,      0, 1, 5, 0,  0, 1, 2, 1, 1005, 1);
    tbl[2]  = mk(0, 0, 0,      1, 0, 0, 0,  0, 1, 2, 0, 1005, 1);
    tbl[3]  = mk(0, 0, 0,      0, 1, 5, 1,  1, 1, 1, 1, 1005, 1);
    tbl[4]  = mk(1, 3, 3003,   0, 0, 0, 0,  1, 1, 1, 0, 1005, 1);
    tbl[5]  = mk(0, 0, 0,      1, 1, 5, 1,  1, 1, 1, 1, 2005, 1);
    tbl[6]  = mk(0, 0, 0,      0, 1, 3, 0,  1, 1, 1, 1, 3003, 1);
    tbl[7]  = mk(0, 0, 0,      0, 1, 5, 0,  1, 1, 1, 1, 1005, 1);
    tbl[8]  = mk(1, 7, 77,     0, 0, 0, 0,  1, 1, 1, 0, 1005, 1);
    tbl[9]  = mk(0, 0, 0,      1, 0, 0, 0,  0, 1, 2, 0, 1005, 1);
    tbl[10] = mk(0, 0, 0,      0, 0, 0, 1,  1, 1, 1, 0, 1005, 1);
    tbl[11] = mk(0, 0, 0,      0, 1, 7, 0,  1, 1, 1, 1, 77,   1);
    tbl[12] = mk(0, 0, 0,      0, 0, 0, 0,  1, 1, 1, 0, 77,   1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_a("idle", 1, 0, 0, 0, 0, 0);
    chk("b_idle.cnt", 128'(b_cnt), 0);
    chk("b_idle.wr_rdy", 128'(b_wrdy), 1);

    // single bank round trip
    for (int i = 0; i < 64; i++) step0(1, i, 128'(i), 0, 0, 0, 0);
    step0(0, 0, 0, 1, 0, 0, 0);
    chk("a_done.rd_rdy", 128'(a_rrdy), 1);
    chk("a_done.cnt", 128'(a_cnt), 1);
    for (int i = 0; i < 64; i++) begin
      step0(0, 0, 0, 0, 1, i, 0);
      chk("a_rd.valid", 128'(a_val), 1);
      chk("a_rd.data", a_rdat, 128'(i));
    end
    step0(0, 0, 0, 0, 0, 0, 1);
    chk_a("a_release", 1, 0, 0, 0, 63, 0);

    // fill both banks
    for (int i = 0; i < 64; i++) step0(1, i, 128'(1000 + i), 0, 0, 0, 0);
    step0(0, 0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) step0(1, i, 128'(2000 + i), 0, 0, 0, 0);
    step0(0, 0, 0, 1, 0, 0, 0);
    chk_a("a_full", 0, 1, 2, 0, 63, 0);

    for (int k = 0; k < 13; k++) begin
      step0(tbl[k].we, tbl[k].wa, tbl[k].wd, tbl[k].wdn,
            tbl[k].re, tbl[k].ra, tbl[k].rdn);
      chk_a($sformatf("vec%0d", k), tbl[k].e_wrdy, tbl[k].e_rrdy,
            tbl[k].e_cnt, tbl[k].e_val, tbl[k].e_dat, tbl[k].e_drop);
    end

    // reset in the middle of a read with one bank full
    a_re = 1; a_ra = 7;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_a("a_rst", 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    step0(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step0(0, 0, 0, 0, 0, 0, 0);
    chk_a("a_post_rst", 1, 0, 0, 0, 0, 0);
    step0(1, 0, 'h55, 0, 0, 0, 0);
    step0(0, 0, 0, 1, 0, 0, 0);
    step0(0, 0, 0, 0, 1, 0, 0);
    chk_a("a_refill", 1, 1, 1, 1, 'h55, 0);
    step0(0, 0, 0, 0, 0, 0, 0);

    run_random();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // queue of completed bank sequence numbers, oldest first
  task automatic run_random();
    int q[$];
    int wseq = 0;
    int waddr = 0;
    int reads = 0;
    int consumed = 0;
    int cyc = 0;
    logic exp_val = 0;
    logic [31:0] exp_dat = 0;
    logic we, wdn, re, rdn;
    int ra;
    while (consumed < 10 && cyc < 5000) begin
      cyc++;
      we  = (q.size() < 4) && (waddr < 8) && ($urandom_range(1) == 1);
      wdn = (q.size() < 4) && (waddr == 8) && ($urandom_range(1) == 1);
      re  = (q.size() > 0) && ($urandom_range(1) == 1);
      rdn = (q.size() > 0) && (reads >= 2) && ($urandom_range(2) == 0);
      ra  = int'($urandom_range(7));
      b_we = we; b_wa = 3'(waddr); b_wd = {24'(wseq), 8'(waddr)};
      b_wdn = wdn; b_re = re; b_ra = 3'(ra); b_rdn = rdn;
      exp_val = re;
      if (re) begin
        exp_dat = {24'(q[0]), 8'(ra)};
        reads++;
      end
      if (we) waddr++;
      if (wdn) begin
        q.push_back(wseq);
        wseq++;
        waddr = 0;
      end
      if (rdn) begin
        void'(q.pop_front());
        consumed++;
        reads = 0;
      end
      @(negedge clk);
      chk("b.cnt", 128'(b_cnt), 128'(q.size()));
      chk("b.wr_rdy", 128'(b_wrdy), 128'(q.size() != 4));
      chk("b.rd_rdy", 128'(b_rrdy), 128'(q.size() != 0));
      chk("b.valid", 128'(b_val), 128'(exp_val));
      if (exp_val) chk("b.data", 128'(b_rdat), 128'(exp_dat));
    end
    b_we = 0; b_wdn = 0; b_re = 0; b_rdn = 0;
    chk("b.banks_consumed", 128'(consumed), 10);
    chk("b.drop", 128'(b_drop), 0);
  endtask

endmodule
